bof_range_ctrl: RTL and testbench

- Owns and sequences the overflow-range table that the heap buffer-overflow tracker fills with completed contiguous-store ranges.
- Shares the single table port between two requesters: range insertion from the tracker and address lookup from the load path.
- Runs a multi-cycle flush sequence over the table.
- Arms, evaluates and raises the crash request when an indirect jump (JALR) follows a load that hit a recorded range.

---
 rtl/bof_range_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_bof_range_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bof_range_ctrl.sv
// Overflow-range table controller for the heap buffer-overflow tracker.
// The table holds completed contiguous-store ranges. Range insertion and
// load-address lookup share one table port, and lookup always wins. A
// multi-cycle flush walks the table and clears it. A JALR that follows a
// load which hit a recorded range raises a one-cycle crash request.
module bof_range_ctrl #(
    parameter int NUM_ENTRIES = 8,
    parameter int ADDR_W      = 32,
    parameter int MIN_SPAN    = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           ins_valid_i,
    output logic                           ins_ready_o,
    input  logic [ADDR_W-1:0]              ins_start_i,
    input  logic [ADDR_W-1:0]              ins_end_i,
    input  logic                           lkp_valid_i,
    input  logic [ADDR_W-1:0]              lkp_addr_i,
    output logic                           lkp_resp_valid_o,
    output logic                           lkp_hit_o,
    input  logic                           flush_i,
    input  logic                           arm_i,
    input  logic                           jalr_i,
    output logic                           crash_o,
    output logic                           busy_o,
    output logic [$clog2(NUM_ENTRIES):0]   count_o
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic [IDX_W-1:0]        clr_idx_reg, clr_idx_next;
    logic [IDX_W-1:0]        wr_ptr_reg;
    logic [CNT_W-1:0]        count_reg;

    logic                    valid_reg [NUM_ENTRIES];
    logic [ADDR_W-1:0]       start_reg [NUM_ENTRIES];
    logic [ADDR_W-1:0]       end_reg   [NUM_ENTRIES];

    logic                    resp_valid_reg;
    logic                    hit_reg;
    logic                    pending_reg;
    logic                    armed_reg;
    logic                    crash_reg;

    logic [NUM_ENTRIES-1:0]  hit_vec;
    logic [NUM_ENTRIES-1:0]  dup_vec;
    logic                    span_ok;
    logic                    ins_fire;
    logic                    ins_write;
    logic                    clr_last;
    logic                    eff_pending;

    // Per-entry range compare for lookup and exact-match compare for dedupe.
    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_cmp
            assign hit_vec[gi] = valid_reg[gi]
                              && (lkp_addr_i >= start_reg[gi])
                              && (lkp_addr_i <= end_reg[gi]);
            assign dup_vec[gi] = valid_reg[gi]
                              && (ins_start_i == start_reg[gi])
                              && (ins_end_i == end_reg[gi]);
        end
    endgenerate

    // Only ranges that are well-formed and at least MIN_SPAN bytes wide count.
    assign span_ok   = (ins_end_i >= ins_start_i)
                    && ((ins_end_i - ins_start_i) >= ADDR_W'(MIN_SPAN));
    assign ins_ready_o = (state_reg == ST_IDLE) && !lkp_valid_i && !flush_i;
    assign ins_fire  = ins_valid_i && ins_ready_o;
    assign ins_write = ins_fire && span_ok && !(|dup_vec);
    assign clr_last  = (state_reg == ST_CLEAR) && !flush_i
                    && (clr_idx_reg == IDX_W'(NUM_ENTRIES - 1));

    // If a lookup response arrives together with a JALR, the response wins.
    assign eff_pending = resp_valid_reg ? hit_reg : pending_reg;

    // Next-state logic for the flush sequencer; flush always restarts at index 0.
    always_comb begin
        state_next   = state_reg;
        clr_idx_next = clr_idx_reg;
        case (state_reg)
            ST_IDLE: begin
                if (flush_i) begin
                    state_next   = ST_CLEAR;
                    clr_idx_next = '0;
                end
            end
            ST_CLEAR: begin
                if (flush_i) begin
                    clr_idx_next = '0;
                end else if (clr_idx_reg == IDX_W'(NUM_ENTRIES - 1)) begin
                    state_next   = ST_IDLE;
                    clr_idx_next = '0;
                end else begin
                    clr_idx_next = clr_idx_reg + 1'b1;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                clr_idx_next = '0;
            end
        endcase
    end

    // Flush sequencer state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= ST_IDLE;
            clr_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_idx_reg <= clr_idx_next;
        end
    end

    // Table entries: cleared one per cycle during flush, else written at the pointer.
    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    valid_reg[gi] <= 1'b0;
                    start_reg[gi] <= '0;
                    end_reg[gi]   <= '0;
                end else if ((state_reg == ST_CLEAR) && (clr_idx_reg == IDX_W'(gi))) begin
                    valid_reg[gi] <= 1'b0;
                end else if (ins_write && (wr_ptr_reg == IDX_W'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                    start_reg[gi] <= ins_start_i;
                    end_reg[gi]   <= ins_end_i;
                end
            end
        end
    endgenerate

    // Write pointer and occupancy; the pointer wraps so a full table overwrites the oldest.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (flush_i) begin
                wr_ptr_reg <= '0;
            end else if (ins_write) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (clr_last) begin
                count_reg <= '0;
            end else if (ins_write && (count_reg != CNT_W'(NUM_ENTRIES))) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    // Registered lookup response; the table reads as empty while a flush runs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_reg <= 1'b0;
            hit_reg        <= 1'b0;
        end else begin
            resp_valid_reg <= lkp_valid_i;
            hit_reg        <= lkp_valid_i && (state_reg == ST_IDLE) && (|hit_vec);
        end
    end

    // Arm, pending-hit tracking and the crash pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            armed_reg   <= 1'b0;
            pending_reg <= 1'b0;
            crash_reg   <= 1'b0;
        end else begin
            armed_reg <= armed_reg | arm_i;
            crash_reg <= jalr_i && armed_reg && eff_pending;
            if (flush_i || jalr_i) begin
                pending_reg <= 1'b0;
            end else if (resp_valid_reg) begin
                pending_reg <= hit_reg;
            end
        end
    end

    assign lkp_resp_valid_o = resp_valid_reg;
    assign lkp_hit_o        = hit_reg;
    assign crash_o          = crash_reg;
    assign busy_o           = (state_reg == ST_CLEAR);
    assign count_o          = count_reg;

endmodule

// File: tb/tb_bof_range_ctrl.sv
// Scoreboard bench for bof_range_ctrl: the driver feeds a behavioural table
// model and queues expected responses, a monitor pops them as the DUT answers.
module tb_bof_range_ctrl;

    localparam int N  = 8;
    localparam int AW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          ins_valid_i;
    logic          ins_ready_o;
    logic [AW-1:0] ins_start_i;
    logic [AW-1:0] ins_end_i;
    logic          lkp_valid_i;
    logic [AW-1:0] lkp_addr_i;
    logic          lkp_resp_valid_o;
    logic          lkp_hit_o;
    logic          flush_i;
    logic          arm_i;
    logic          jalr_i;
    logic          crash_o;
    logic          busy_o;
    logic [CW-1:0] count_o;

    bof_range_ctrl #(.NUM_ENTRIES(N), .ADDR_W(AW), .MIN_SPAN(32)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .ins_valid_i      (ins_valid_i),
        .ins_ready_o      (ins_ready_o),
        .ins_start_i      (ins_start_i),
        .ins_end_i        (ins_end_i),
        .lkp_valid_i      (lkp_valid_i),
        .lkp_addr_i       (lkp_addr_i),
        .lkp_resp_valid_o (lkp_resp_valid_o),
        .lkp_hit_o        (lkp_hit_o),
        .flush_i          (flush_i),
        .arm_i            (arm_i),
        .jalr_i           (jalr_i),
        .crash_o          (crash_o),
        .busy_o           (busy_o),
        .count_o          (count_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [AW-1:0] s; logic [AW-1:0] e; } rng_t;
    typedef struct { int c; logic hit; } lkp_exp_t;

    // Reference model: ranges kept oldest-first, table occupancy is the queue size.
    rng_t     mq[$];
    lkp_exp_t lq[$];
    int       cq[$];
    int       busy_left;
    logic     m_armed, m_pend, m_resp_v, m_resp_hit;
    lkp_exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic m_covers(input logic [AW-1:0] a);
        foreach (mq[i]) if (a >= mq[i].s && a <= mq[i].e) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_has(input logic [AW-1:0] s, input logic [AW-1:0] e);
        foreach (mq[i]) if (mq[i].s == s && mq[i].e == e) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete(); lq.delete(); cq.delete();
        busy_left = 0; m_armed = 0; m_pend = 0; m_resp_v = 0; m_resp_hit = 0;
    endtask

    // Monitor: compare every lookup response and crash pulse against the queues.
    always @(negedge clk) begin
        if (rst_ni) begin
            while (lq.size() > 0 && lq[0].c < cyc) begin
                chk("lkp_missing", 32'd0, 32'd1);
                void'(lq.pop_front());
            end
            while (cq.size() > 0 && cq[0] < cyc) begin
                chk("crash_missing", 32'd0, 32'd1);
                void'(cq.pop_front());
            end
            if (lkp_resp_valid_o) begin
                if (lq.size() == 0) chk("lkp_unexpected", 32'd1, 32'd0);
                else begin
                    mon_e = lq.pop_front();
                    chk("lkp_cycle", cyc, mon_e.c);
                    chk("lkp_hit", {31'd0, lkp_hit_o}, {31'd0, mon_e.hit});
                    $display("lookup resp cyc=%0d hit=%0b exp=%0b", cyc, lkp_hit_o, mon_e.hit);
                end
            end
            if (crash_o) begin
                if (cq.size() == 0) chk("crash_unexpected", 32'd1, 32'd0);
                else begin
                    chk("crash_cycle", cyc, cq.pop_front());
                    $display("crash pulse cyc=%0d", cyc);
                end
            end
        end
    end

    // One clock of stimulus: check state outputs, apply inputs, advance the model.
    task automatic drive(input logic iv, input logic [AW-1:0] s, input logic [AW-1:0] e,
                         input logic lv, input logic [AW-1:0] la,
                         input logic fl, input logic ar, input logic jr);
        logic m_busy, m_ready, exp_hit, eff;
        @(negedge clk);
        m_busy = (busy_left > 0);
        chk("busy", {31'd0, busy_o}, {31'd0, m_busy});
        if (!m_busy) chk("count", {28'd0, count_o}, mq.size());
        ins_valid_i = iv; ins_start_i = s; ins_end_i = e;
        lkp_valid_i = lv; lkp_addr_i = la;
        flush_i = fl; arm_i = ar; jalr_i = jr;
        #1;
        m_ready = !m_busy && !lv && !fl;
        chk("ins_ready", {31'd0, ins_ready_o}, {31'd0, m_ready});
        exp_hit = !m_busy && m_covers(la);
        if (lv) lq.push_back('{c: cyc + 1, hit: exp_hit});
        if (iv && m_ready && e >= s && (e - s) >= 32 && !m_has(s, e)) begin
            if (mq.size() == N) void'(mq.pop_front());
            mq.push_back('{s: s, e: e});
        end
        eff = m_resp_v ? m_resp_hit : m_pend;
        if (jr && m_armed && eff) cq.push_back(cyc + 1);
        if (fl || jr) m_pend = 1'b0;
        else if (m_resp_v) m_pend = m_resp_hit;
        m_armed    = m_armed | ar;
        m_resp_v   = lv;
        m_resp_hit = lv && exp_hit;
        if (fl) begin
            busy_left = N;
            mq.delete();
        end else if (busy_left > 0) begin
            busy_left = busy_left - 1;
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic ins(input logic [AW-1:0] s, input logic [AW-1:0] e);
        drive(1, s, e, 0, 0, 0, 0, 0);
    endtask
    task automatic lkp(input logic [AW-1:0] a);
        drive(0, 0, 0, 1, a, 0, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] rs, re, ra;
        rst_ni = 0; ins_valid_i = 0; ins_start_i = 0; ins_end_i = 0;
        lkp_valid_i = 0; lkp_addr_i = 0; flush_i = 0; arm_i = 0; jalr_i = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_count", {28'd0, count_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_crash", {31'd0, crash_o}, 32'd0);
        chk("rst_resp_valid", {31'd0, lkp_resp_valid_o}, 32'd0);
        chk("rst_hit", {31'd0, lkp_hit_o}, 32'd0);
        rst_ni = 1;

        // Basic insert and lookups
        ins(32'h1000, 32'h1040);
        idle();
        lkp(32'h1020);
        lkp(32'h1044);
        // Short span, inverted range, duplicate
        ins(32'h2000, 32'h2010);
        ins(32'h2000, 32'h1FF0);
        ins(32'h1000, 32'h1040);
        idle();
        chk("tp2_count", {28'd0, count_o}, 32'd1);
        // Nine distinct inserts into a depth-8 table
        for (int i = 0; i < 9; i++) ins(32'h10000 + i * 32'h100, 32'h10040 + i * 32'h100);
        idle();
        chk("tp3_count", {28'd0, count_o}, 32'd8);
        lkp(32'h10020);
        lkp(32'h10820);
        // Lookup holds off a concurrent insert
        drive(1, 32'h3000, 32'h3040, 1, 32'h10820, 0, 0, 0);
        drive(1, 32'h3000, 32'h3040, 1, 32'h10720, 0, 0, 0);
        ins(32'h3000, 32'h3040);
        idle();
        lkp(32'h3010);
        // Crash sequencing: unarmed, armed, then a miss in between
        lkp(32'h3010); idle(); drive(0, 0, 0, 0, 0, 0, 0, 1); idle(); idle();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        lkp(32'h3010); idle(); drive(0, 0, 0, 0, 0, 0, 0, 1); idle(); idle();
        lkp(32'h3010); lkp(32'h9000); idle(); drive(0, 0, 0, 0, 0, 0, 0, 1); idle(); idle();
        lkp(32'h3010); drive(0, 0, 0, 0, 0, 0, 0, 1); idle(); idle();
        // Flush a full table, then restart the flush on its fourth busy cycle
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            if (i == 3) drive(1, 32'h3000, 32'h3040, 1, 32'h3010, 1, 0, 0);
            else drive(1, 32'h4000, 32'h4040, 1, 32'h10820, 0, 0, 0);
        end
        idle();
        chk("tp6_count", {28'd0, count_o}, 32'd0);
        // Reset in the middle of a flush
        ins(32'h5000, 32'h5040);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        idle(); idle();
        @(negedge clk); #2;
        rst_ni = 0;
        #1;
        chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_mid_count", {28'd0, count_o}, 32'd0);
        ins_valid_i = 0; lkp_valid_i = 0; flush_i = 0; arm_i = 0; jalr_i = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_ni = 1;

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rs = $urandom_range(0, 15) * 16;
            re = rs + $urandom_range(0, 4) * 16;
            if ($urandom_range(0, 7) == 0) re = rs - 16;
            ra = $urandom_range(0, 320);
            drive($urandom_range(0, 2) == 0, rs, re,
                  $urandom_range(0, 2) == 0, ra,
                  $urandom_range(0, 99) == 0,
                  $urandom_range(0, 199) == 0,
                  $urandom_range(0, 5) == 0);
        end
        repeat (N + 3) idle();
        chk("lkp_queue_drained", lq.size(), 32'd0);
        chk("crash_queue_drained", cq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
